cmp_seq_slice: RTL and testbench
================================

// Module: cmp_seq_slice
// PURPOSE
//  Parametrised multi-cycle magnitude comparator for a WIDTH-bit word pair, signed or unsigned per transaction.
//  Scans from the MSB in SLICE-bit steps, one slice per clock, and stops at the first differing slice (early exit).
//  Reports gt/eq/lt/gteq through a valid/ready result port.
//  Sits between operand registers and downstream decision logic where a full-width single-cycle compare is too slow.
// PARAMETERS
//  WIDTH   8   operand width in bits; must be >= 2 and an integer multiple of SLICE
//  SLICE   2   bits compared per cycle; NSLICE = WIDTH/SLICE
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset_n    in   1      synchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  is_signed  in   1      1 = two's-complement compare, 0 = unsigned; sampled with a/b
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  agtb       out  1      A > B
//  aeqb       out  1      A == B
//  altb       out  1      A < B
//  agteqb     out  1      A >= B (= agtb | aeqb)
// BEHAVIOUR
//  - Reset (reset_n low at a clk edge): state=IDLE, out_valid=0, agtb=aeqb=altb=agteqb=0, slice index cleared.
//    in_ready is forced 0 while reset_n is low. Reset overrides every other input, including mid-SCAN and mid-DONE.
//  - Operand and mode registers are loaded only on accept (in_valid & in_ready). Inputs are ignored at all other times.
//  - FSM states: IDLE, SCAN, DONE.
//    IDLE: in_ready=1. On accept, latch a, b and is_signed, then:
//      - if is_signed and a[WIDTH-1] != b[WIDTH-1], go to DONE with the sign-decided result (A negative -> lt);
//      - otherwise go to SCAN with idx = NSLICE-1 (MSB slice).
//    SCAN: compare slice idx of the latched A and B as unsigned SLICE-bit values.
//      - A slice > B slice -> gt, go to DONE.
//      - A slice < B slice -> lt, go to DONE.
//      - equal and idx==0 -> eq, go to DONE.
//      - equal and idx>0 -> idx-1, stay in SCAN.
//      - Same-sign signed operands use the unsigned scan; this is correct for two's complement.
//    DONE: out_valid=1 and exactly one of agtb/aeqb/altb is 1. On out_ready=1, go to IDLE; out_valid falls on the next edge.
//  - Flag values are stable throughout DONE. Flags are cleared to 0 on leaving DONE.
//  - Latency, with accept at edge t: out_valid is high after edge t+1 for a sign decision.
//    Otherwise it is high after edge t+k, where k = (NSLICE - index of the first differing slice), or NSLICE if the words are equal.
//  - Back-to-back operation: no accept is possible in DONE, so the minimum spacing between accepts is k+2 cycles (IDLE bubble).
//  - Backpressure: out_ready low holds DONE indefinitely, with outputs unchanged and in_ready=0.
//  - out_ready while out_valid=0 has no effect. in_valid while in_ready=0 has no effect and is not queued.
//  - Elaboration: parameter violation (WIDTH % SLICE != 0 or WIDTH < 2) triggers $error.
// TESTING
//  Defaults (WIDTH=8, SLICE=2) unless noted; "lat" = edges from accept to out_valid high.
//  1. signed, a=8'h80 (-128), b=8'h7F (127) -> altb=1, agteqb=0, lat=1 (sign path).
//     Same operands unsigned -> agtb=1, agteqb=1, lat=1 (MSB slice 2'b10 > 2'b01).
//  2. unsigned, a=b=8'h5A -> aeqb=1, agteqb=1, agtb=altb=0, lat=4.
//     signed, a=b=8'hFF -> aeqb=1, lat=4.
//  3. unsigned, a=8'h01, b=8'h00 -> agtb=1, lat=4.
//     a=8'h10, b=8'h20 -> altb=1, lat=2.
//     signed, a=8'hFE (-2), b=8'hFF (-1) -> altb=1, lat=4.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> flags constant, in_ready=0, no second accept.
//     Raise out_ready -> IDLE next edge, in_ready=1.
//  5. Drive reset_n=0 for one edge during SCAN (a=8'h00, b=8'h01, after 2 cycles) -> all outputs 0, in_ready=0 during reset.
//     After release, a new accept of a=8'h03, b=8'h02 gives agtb=1, lat=4.
//  6. WIDTH=16, SLICE=4: a=16'h8000, b=16'h0001 -> signed altb=1, lat=1; unsigned agtb=1, lat=1.
//     Then run a 2000-vector random sweep of both modes against a behavioural $signed/unsigned compare -> zero mismatches.

Source files
------------

// File: rtl/cmp_seq_slice.sv
// cmp_seq_slice
//   Multi-cycle magnitude comparator for a WIDTH-bit operand pair. The pair is
//   compared as signed or unsigned, selected per transaction. Slices of SLICE
//   bits are compared from the MSB down, one slice per clock. The scan stops at
//   the first slice that differs. The result is held on a valid/ready port
//   until downstream accepts it.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only, low during reset)
//   a, b       operands, WIDTH bits
//   is_signed  1 = two's-complement compare, 0 = unsigned (sampled with a/b)
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   agtb       A > B
//   aeqb       A == B
//   altb       A < B
//   agteqb     A >= B
module cmp_seq_slice #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb,
  output logic             agteqb
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // The MSB slice is compared in the accept cycle, so a scan that continues
  // starts one slice lower. This gives a latency of one edge for an MSB-slice
  // difference and NSLICE edges for equal words.
  localparam logic [IDXW-1:0] IDX_START = (NSLICE > 1) ? IDXW'(NSLICE - 2) : '0;

  if ((WIDTH % SLICE) != 0 || WIDTH < 2) begin : g_param_check
    $error("cmp_seq_slice: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              gt_q, eq_q, lt_q;
  logic              gt_d, eq_d, lt_d;
  logic              load;

  logic [SLICE-1:0]  top_a, top_b;
  logic [SLICE-1:0]  scan_a, scan_b;

  assign top_a  = a[WIDTH-1 -: SLICE];
  assign top_b  = b[WIDTH-1 -: SLICE];
  assign scan_a = a_q[idx_q*SLICE +: SLICE];
  assign scan_b = b_q[idx_q*SLICE +: SLICE];

  assign in_ready  = reset_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign agtb      = gt_q;
  assign aeqb      = eq_q;
  assign altb      = lt_q;
  assign agteqb    = gt_q | eq_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load = 1'b1;
          if (is_signed && (a[WIDTH-1] != b[WIDTH-1])) begin
            // Opposite signs: the negative operand is the smaller one.
            state_d = DONE;
            lt_d    = a[WIDTH-1];
            gt_d    = b[WIDTH-1];
          end else if (top_a > top_b) begin
            state_d = DONE;
            gt_d    = 1'b1;
          end else if (top_a < top_b) begin
            state_d = DONE;
            lt_d    = 1'b1;
          end else if (NSLICE == 1) begin
            state_d = DONE;
            eq_d    = 1'b1;
          end else begin
            state_d = SCAN;
            idx_d   = IDX_START;
          end
        end
      end

      SCAN: begin
        // Same-sign operands order identically as signed or unsigned values,
        // so an unsigned slice scan covers both modes.
        if (scan_a > scan_b) begin
          state_d = DONE;
          gt_d    = 1'b1;
        end else if (scan_a < scan_b) begin
          state_d = DONE;
          lt_d    = 1'b1;
        end else if (idx_q == '0) begin
          state_d = DONE;
          eq_d    = 1'b1;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          idx_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        gt_d    = 1'b0;
        eq_d    = 1'b0;
        lt_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq_slice.sv
module tb_cmp_seq_slice;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit / 2-bit slice instance
  logic       v8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       rdy8, ov8, gt8, eq8, lt8, ge8;

  // 16-bit / 4-bit slice instance
  logic        v16 = 1'b0, s16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, ov16, gt16, eq16, lt16, ge16;

  int n_checks = 0;
  int n_fail   = 0;

  cmp_seq_slice #(.WIDTH(8), .SLICE(2)) dut8 (
    .clk(clk), .reset_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .is_signed(s8), .out_valid(ov8), .out_ready(or8),
    .agtb(gt8), .aeqb(eq8), .altb(lt8), .agteqb(ge8)
  );

  cmp_seq_slice #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .a(a16), .b(b16), .is_signed(s16), .out_valid(ov16), .out_ready(or16),
    .agtb(gt16), .aeqb(eq16), .altb(lt16), .agteqb(ge16)
  );

  // Flag vectors are {gt, eq, lt, gteq}
  localparam logic [3:0] F_GT = 4'b1001;
  localparam logic [3:0] F_EQ = 4'b0101;
  localparam logic [3:0] F_LT = 4'b0010;

  // Reference: numeric compare of the w-bit values, and the edge count
  // implied by the position of the most significant differing slice.
  function automatic void model(input logic [15:0] ta, input logic [15:0] tbv,
                                input int w, input int sl, input logic ts,
                                output logic [3:0] fl, output int lat);
    longint va, vb;
    int ns, sa, sb;
    va = longint'(ta);
    vb = longint'(tbv);
    if (ts && ta[w-1])  va = va - (longint'(1) << w);
    if (ts && tbv[w-1]) vb = vb - (longint'(1) << w);
    if (va > vb)       fl = F_GT;
    else if (va == vb) fl = F_EQ;
    else               fl = F_LT;
    ns  = w / sl;
    lat = ns;
    if (ts && (ta[w-1] != tbv[w-1])) begin
      lat = 1;
    end else begin
      for (int i = ns - 1; i >= 0; i--) begin
        sa = (int'(ta)  >> (i * sl)) & ((1 << sl) - 1);
        sb = (int'(tbv) >> (i * sl)) & ((1 << sl) - 1);
        if (sa != sb) begin
          lat = ns - i;
          break;
        end
      end
    end
  endfunction

  // One transaction on the 8-bit instance; lat = 99 if out_valid never rises.
  task automatic txn8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                      input int hold, output int lat, output logic [3:0] fl);
    @(negedge clk);
    a8 = ta; b8 = tbv; s8 = ts; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    lat = 1;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov8) lat = 99;
    fl = {gt8, eq8, lt8, ge8};
    repeat (hold) @(posedge clk);
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
  endtask

  task automatic txn16(input logic [15:0] ta, input logic [15:0] tbv, input logic ts,
                       input int hold, output int lat, output logic [3:0] fl);
    @(negedge clk);
    a16 = ta; b16 = tbv; s16 = ts; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    lat = 1;
    while (!ov16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov16) lat = 99;
    fl = {gt16, eq16, lt16, ge16};
    repeat (hold) @(posedge clk);
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1; or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rdy8, ov8, gt8, eq8, lt8, ge8} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset8: got rdy/ov/flags=%b required 000000", {rdy8, ov8, gt8, eq8, lt8, ge8});
    end
    n_checks++;
    if ({rdy16, ov16, gt16, eq16, lt16, ge16} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset16: got rdy/ov/flags=%b required 000000", {rdy16, ov16, gt16, eq16, lt16, ge16});
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++;
    if ({rdy8, rdy16} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 11", {rdy8, rdy16});
    end
  endtask

  // Directed vectors with hand-derived results on the 8-bit instance.
  task automatic test_directed();
    logic [7:0] va [8] = '{8'h80, 8'h80, 8'h5A, 8'hFF, 8'h01, 8'h10, 8'hFE, 8'h7F};
    logic [7:0] vb [8] = '{8'h7F, 8'h7F, 8'h5A, 8'hFF, 8'h00, 8'h20, 8'hFF, 8'h80};
    logic       vs [8] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [3:0] ef [8] = '{F_LT,  F_GT,  F_EQ,  F_EQ,  F_GT,  F_LT,  F_LT,  F_GT};
    int         el [8] = '{1,     1,     4,     4,     4,     2,     4,     1};
    int lat;
    logic [3:0] fl;
    for (int unsigned i = 0; i < 8; i++) begin
      txn8(va[i], vb[i], vs[i], 0, lat, fl);
      n_checks++;
      if (fl !== ef[i]) begin
        n_fail++;
        $display("FAIL directed%0d_flags: a=%h b=%h s=%b got %b required %b", i, va[i], vb[i], vs[i], fl, ef[i]);
      end
      n_checks++;
      if (lat != el[i]) begin
        n_fail++;
        $display("FAIL directed%0d_latency: a=%h b=%h s=%b got %0d required %0d", i, va[i], vb[i], vs[i], lat, el[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; s8 = 1'b0; v8 = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!ov8 && waited < 40);
    n_checks++;
    if (!ov8) begin
      n_fail++;
      $display("FAIL bp_done_timeout: out_valid got 0 required 1");
    end
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      v8 = i[0]; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({ov8, rdy8, gt8, eq8, lt8, ge8} !== {2'b10, F_LT}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ov/rdy/flags got %b required %b", i, {ov8, rdy8, gt8, eq8, lt8, ge8}, {2'b10, F_LT});
      end
    end
    @(negedge clk); v8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
    n_checks++;
    if ({ov8, rdy8, gt8, eq8, lt8, ge8} !== 6'b010000) begin
      n_fail++;
      $display("FAIL bp_release: ov/rdy/flags got %b required 010000", {ov8, rdy8, gt8, eq8, lt8, ge8});
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_no_queued_accept: out_valid got %b required 0", ov8);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    logic [3:0] fl;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; s8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1; v8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_scan_ready_low: in_ready got %b required 0", rdy8);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rdy8, ov8, gt8, eq8, lt8, ge8} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_scan_outputs: rdy/ov/flags got %b required 000000", {rdy8, ov8, gt8, eq8, lt8, ge8});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ov8, rdy8} !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_scan_idle: ov/rdy got %b required 01", {ov8, rdy8});
      end
    end
    txn8(8'h03, 8'h02, 1'b0, 0, lat, fl);
    n_checks++;
    if (fl !== F_GT || lat != 4) begin
      n_fail++;
      $display("FAIL rst_scan_after: flags/lat got %b/%0d required %b/4", fl, lat, F_GT);
    end
  endtask

  task automatic test_random8(input int unsigned n);
    logic [7:0] ra, rb;
    logic rs;
    logic [3:0] fl, efl;
    int lat, elat;
    for (int unsigned i = 0; i < n; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 8'($urandom);
        1: rb = ra;
        2: rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = ra ^ 8'($urandom_range(0, 15));
      endcase
      rs = 1'($urandom);
      model({8'h00, ra}, {8'h00, rb}, 8, 2, rs, efl, elat);
      txn8(ra, rb, rs, $urandom_range(0, 2), lat, fl);
      n_checks++;
      if (fl !== efl || lat != elat) begin
        n_fail++;
        $display("FAIL rand8: a=%h b=%h s=%b flags/lat got %b/%0d required %b/%0d", ra, rb, rs, fl, lat, efl, elat);
      end
    end
  endtask

  task automatic test_wide();
    int lat;
    logic [3:0] fl;
    logic [15:0] ra, rb;
    logic rs;
    logic [3:0] efl;
    int elat;
    txn16(16'h8000, 16'h0001, 1'b1, 0, lat, fl);
    n_checks++;
    if (fl !== F_LT || lat != 1) begin
      n_fail++;
      $display("FAIL wide_signed: flags/lat got %b/%0d required %b/1", fl, lat, F_LT);
    end
    txn16(16'h8000, 16'h0001, 1'b0, 0, lat, fl);
    n_checks++;
    if (fl !== F_GT || lat != 1) begin
      n_fail++;
      $display("FAIL wide_unsigned: flags/lat got %b/%0d required %b/1", fl, lat, F_GT);
    end
    for (int unsigned i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = ra;
        2: rb = ra ^ (16'h0001 << $urandom_range(0, 15));
        default: rb = ra ^ 16'($urandom_range(0, 255));
      endcase
      rs = 1'($urandom);
      model(ra, rb, 16, 4, rs, efl, elat);
      txn16(ra, rb, rs, $urandom_range(0, 2), lat, fl);
      n_checks++;
      if (fl !== efl || lat != elat) begin
        n_fail++;
        $display("FAIL rand16: a=%h b=%h s=%b flags/lat got %b/%0d required %b/%0d", ra, rb, rs, fl, lat, efl, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random8(300);
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
